// File: rtl/snr_db_converter_pkg.sv
// Shared constants, Q-format widths and FSM state type for the SNR dB converter.
package snr_db_converter_pkg;

    localparam int unsigned K_10LOG10_2_Q12 = 12330;
    localparam int unsigned INT_W           = 6;
    localparam int unsigned MANT_W          = 16;
    localparam int unsigned DB_W            = 16;

    localparam logic signed [DB_W-1:0] DB_MIN     = 16'sh8000;
    localparam logic signed [DB_W-1:0] DB_MAX     = 16'sh7FFF;
    localparam logic signed [DB_W-1:0] DB_NEG_SAT = 16'sh8001;

    typedef enum logic [2:0] {
        IDLE,
        NORM,
        FRAC,
        SCALE,
        DONE
    } state_t;

endpackage

// File: rtl/snr_db_converter_log2_fixed.sv
// Iterative fixed-point log2 of an unsigned Q(IN_WIDTH/2).(IN_WIDTH/2) value:
// one normalize cycle on go, then one squaring cycle per fractional bit.
module log2_fixed
    import snr_db_converter_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned IN_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    go,
    input  logic [IN_WIDTH-1:0]     x,
    output logic signed [INT_W-1:0] int_part,
    output logic [FRAC_BITS-1:0]    frac_part,
    output logic                    ready
);

    localparam int unsigned P_W     = $clog2(IN_WIDTH);
    localparam int unsigned IN_FRAC = IN_WIDTH / 2;

    logic [P_W-1:0]    lead;
    logic [MANT_W-1:0] m_init;
    logic [MANT_W-1:0] m;
    logic [MANT_W:0]   sq_top;
    logic [MANT_W-1:0] m_next;
    logic [3:0]        cnt;
    logic              running;

    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i < IN_WIDTH; i++) begin
            if (x[i]) lead = P_W'(i);
        end
        m_init = MANT_W'((x << (P_W'(IN_WIDTH - 1) - lead)) >> (IN_WIDTH - MANT_W));
        // Q2.30 square kept from bit 15 up: bit 16 is the integer-2 flag.
        sq_top = (MANT_W + 1)'(((2 * MANT_W)'(m) * (2 * MANT_W)'(m)) >> (MANT_W - 1));
        m_next = sq_top[MANT_W] ? sq_top[MANT_W:1] : sq_top[MANT_W-1:0];
    end

    // Asserted during the cycle that produces the final fractional bit.
    assign ready = running && (cnt == 4'(FRAC_BITS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            int_part  <= '0;
            frac_part <= '0;
            m         <= '0;
            cnt       <= '0;
            running   <= 1'b0;
        end else if (go) begin
            int_part  <= $signed(INT_W'(lead) - INT_W'(IN_FRAC));
            frac_part <= '0;
            m         <= m_init;
            cnt       <= '0;
            running   <= 1'b1;
        end else if (running) begin
            frac_part <= FRAC_BITS'({frac_part, sq_top[MANT_W]});
            m         <= m_next;
            cnt       <= cnt + 4'd1;
            if (ready) running <= 1'b0;
        end
    end

endmodule

// File: rtl/snr_db_converter.sv
// Converts a Q16.16 linear SNR to signed Q8.8 dB via log2 and a 10*log10(2) scale,
// behind a 4-phase start/done handshake.
module snr_db_converter
    import snr_db_converter_pkg::*;
#(
    parameter int unsigned FRAC_BITS = 8,
    parameter int unsigned IN_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_db,
    input  logic [IN_WIDTH-1:0]    snr_linear,
    output logic signed [DB_W-1:0] snr_db,
    output logic                   done_snr_db,
    output logic                   busy,
    output logic                   zero_input
);

    localparam int unsigned L_W    = INT_W + FRAC_BITS;
    localparam int unsigned PROD_W = L_W + 16;

    localparam logic signed [PROD_W-1:0] K_EXT      = PROD_W'(K_10LOG10_2_Q12);
    localparam logic signed [PROD_W-1:0] ROUND_HALF = PROD_W'(1) <<< (FRAC_BITS + 3);

    state_t                   state;
    logic [IN_WIDTH-1:0]      x_reg;
    logic                     log_go;
    logic                     log_ready;
    logic signed [INT_W-1:0]  int_part;
    logic [FRAC_BITS-1:0]     frac_part;
    logic signed [L_W-1:0]    l_val;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] shifted;
    logic signed [DB_W-1:0]   db_sat;

    log2_fixed #(
        .FRAC_BITS (FRAC_BITS),
        .IN_WIDTH  (IN_WIDTH)
    ) u_log2 (
        .clk       (clk),
        .reset     (reset),
        .go        (log_go),
        .x         (x_reg),
        .int_part  (int_part),
        .frac_part (frac_part),
        .ready     (log_ready)
    );

    always_comb begin
        l_val   = $signed({int_part, frac_part});
        prod    = PROD_W'(l_val) * K_EXT;
        shifted = (prod + ROUND_HALF) >>> (FRAC_BITS + 4);
        if (shifted > PROD_W'(DB_MAX)) begin
            db_sat = DB_MAX;
        end else if (shifted < PROD_W'(DB_NEG_SAT)) begin
            db_sat = DB_NEG_SAT;
        end else begin
            db_sat = DB_W'(shifted);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            x_reg       <= '0;
            log_go      <= 1'b0;
            snr_db      <= '0;
            done_snr_db <= 1'b0;
            busy        <= 1'b0;
            zero_input  <= 1'b0;
        end else begin
            log_go <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_db) begin
                        x_reg      <= snr_linear;
                        busy       <= 1'b1;
                        zero_input <= 1'b0;
                        if (snr_linear == '0) begin
                            zero_input <= 1'b1;
                            snr_db     <= DB_MIN;
                            state      <= DONE;
                        end else begin
                            log_go <= 1'b1;
                            state  <= NORM;
                        end
                    end
                end
                NORM:  state <= FRAC;
                FRAC:  if (log_ready) state <= SCALE;
                SCALE: begin
                    snr_db <= db_sat;
                    state  <= DONE;
                end
                DONE: begin
                    // done rises on the first DONE edge even if start already fell.
                    if (done_snr_db && !start_db) begin
                        done_snr_db <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        done_snr_db <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snr_db_converter.sv
// Self-checking bench for snr_db_converter: known vectors, handshake, reset and random sweep.
module tb_snr_db_converter;

    logic               clk = 1'b0;
    logic               reset;
    logic               start_db;
    logic [31:0]        snr_linear;
    logic signed [15:0] snr_db;
    logic               done_snr_db;
    logic               busy;
    logic               zero_input;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    snr_db_converter #(
        .FRAC_BITS (8),
        .IN_WIDTH  (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start_db    (start_db),
        .snr_linear  (snr_linear),
        .snr_db      (snr_db),
        .done_snr_db (done_snr_db),
        .busy        (busy),
        .zero_input  (zero_input)
    );

    // Arithmetic model: leading-one normalize, 8 squaring steps, scale by 12330/4096, round half-up.
    function automatic int model_db(input logic [31:0] x);
        int     p;
        int     frac;
        longint m, sq, l, r;
        if (x == 0) return -32768;
        p = 0;
        for (int i = 0; i < 32; i++) if (x[i]) p = i;
        m = (longint'(x) << (31 - p)) >> 16;
        frac = 0;
        for (int k = 0; k < 8; k++) begin
            sq = m * m;
            if (sq >= (longint'(1) << 31)) begin
                frac = frac * 2 + 1;
                m    = sq >> 16;
            end else begin
                frac = frac * 2;
                m    = sq >> 15;
            end
        end
        l = longint'(p - 16) * 256 + frac;
        r = (l * 12330 + 2048) >>> 12;
        if (r > 32767) r = 32767;
        if (r < -32767) r = -32767;
        return int'(r);
    endfunction

    task automatic wait_done(output int edges);
        edges = 0;
        while (!done_snr_db && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        if (!done_snr_db) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: done_snr_db=%0b after %0d edges, required 1", done_snr_db, edges);
        end
    endtask

    task automatic convert(input logic [31:0] x, output int edges);
        @(negedge clk);
        snr_linear = x;
        start_db   = 1'b1;
        @(negedge clk);
        wait_done(edges);
    endtask

    task automatic release_start();
        @(negedge clk);
        start_db = 1'b0;
        @(negedge clk);
        checks++;
        if (done_snr_db !== 1'b0) begin
            failures++;
            $display("FAIL done_release: done_snr_db=%0b, required 0", done_snr_db);
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        start_db   = 1'b0;
        snr_linear = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({snr_db, done_snr_db, busy, zero_input} !== 19'd0) begin
            failures++;
            $display("FAIL reset_state: db=%h done=%b busy=%b zero=%b, required all 0",
                     snr_db, done_snr_db, busy, zero_input);
        end
        reset = 1'b0;
    endtask

    task automatic test_known();
        logic [31:0] xs   [7] = '{32'h0001_0000, 32'h0000_8000, 32'h000A_0000, 32'h0064_0000,
                                  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        int          exps [7] = '{0, -771, 2559, 5120, -12329, 12329, -32768};
        int          tols [7] = '{0, 0, 0, 3, 3, 3, 0};
        int          edges;
        int          diff;
        for (int i = 0; i < 7; i++) begin
            convert(xs[i], edges);
            checks++;
            if (edges != ((xs[i] == 0) ? 1 : 11)) begin
                failures++;
                $display("FAIL known_latency[%0d]: edges=%0d, required %0d", i, edges, (xs[i] == 0) ? 1 : 11);
            end
            diff = int'(snr_db) - exps[i];
            checks++;
            if (diff < -tols[i] || diff > tols[i]) begin
                failures++;
                $display("FAIL known_db[%0d]: snr_db=%h, required %0d +/- %0d", i, snr_db, exps[i], tols[i]);
            end
            checks++;
            if (int'(snr_db) != model_db(xs[i])) begin
                failures++;
                $display("FAIL known_model[%0d]: snr_db=%0d, required %0d", i, snr_db, model_db(xs[i]));
            end
            checks++;
            if (zero_input !== (xs[i] == 0) || busy !== 1'b0) begin
                failures++;
                $display("FAIL known_flags[%0d]: zero=%b busy=%b, required zero=%b busy=0",
                         i, zero_input, busy, xs[i] == 0);
            end
            release_start();
        end
    endtask

    task automatic test_busy();
        int edges;
        @(negedge clk);
        snr_linear = 32'h0003_0000;
        start_db   = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || done_snr_db !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_accept: busy=%b done=%b, required busy=1 done=0", busy, done_snr_db);
        end
        wait_done(edges);
        release_start();
    endtask

    task automatic test_handshake();
        int                 edges;
        logic signed [15:0] held;
        @(negedge clk);
        snr_linear = 32'h0000_4000;
        start_db   = 1'b1;
        @(negedge clk);
        repeat (4) @(negedge clk);
        snr_linear = 32'h1234_5678;
        start_db   = 1'b0;
        @(negedge clk);
        start_db = 1'b1;
        wait_done(edges);
        edges += 5;
        checks++;
        if (edges != 11 || int'(snr_db) != model_db(32'h0000_4000)) begin
            failures++;
            $display("FAIL hs_disturb: edges=%0d db=%0d, required edges=11 db=%0d",
                     edges, snr_db, model_db(32'h0000_4000));
        end
        held = snr_db;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if (done_snr_db !== 1'b1 || busy !== 1'b0 || snr_db !== held) begin
                failures++;
                $display("FAIL hs_hold[%0d]: done=%b busy=%b db=%h, required done=1 busy=0 db=%h",
                         c, done_snr_db, busy, snr_db, held);
            end
        end
        start_db = 1'b0;
        @(negedge clk);
        checks++;
        if (done_snr_db !== 1'b0) begin
            failures++;
            $display("FAIL hs_drop: done=%b, required 0", done_snr_db);
        end
        snr_linear = 32'h0003_0000;
        start_db   = 1'b1;
        @(negedge clk);
        wait_done(edges);
        checks++;
        if (edges != 11 || int'(snr_db) != model_db(32'h0003_0000)) begin
            failures++;
            $display("FAIL hs_second: edges=%0d db=%0d, required edges=11 db=%0d",
                     edges, snr_db, model_db(32'h0003_0000));
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        int edges;
        @(negedge clk);
        snr_linear = 32'h0000_0300;
        start_db   = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({snr_db, done_snr_db, busy, zero_input} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid: db=%h done=%b busy=%b zero=%b, required all 0",
                     snr_db, done_snr_db, busy, zero_input);
        end
        reset    = 1'b0;
        start_db = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_snr_db !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done_snr_db);
        end
        convert(32'h0000_0300, edges);
        checks++;
        if (edges != 11 || int'(snr_db) != model_db(32'h0000_0300)) begin
            failures++;
            $display("FAIL reset_fresh: edges=%0d db=%0d, required edges=11 db=%0d",
                     edges, snr_db, model_db(32'h0000_0300));
        end
        release_start();
    endtask

    task automatic test_random();
        logic [31:0] x;
        int          edges;
        int          exp_db;
        for (int n = 0; n < 1000; n++) begin
            x      = $urandom >> $urandom_range(0, 31);
            exp_db = model_db(x);
            convert(x, edges);
            checks++;
            if (edges != ((x == 0) ? 1 : 11) || int'(snr_db) != exp_db || zero_input !== (x == 0)) begin
                failures++;
                $display("FAIL random[%0d] x=%h: edges=%0d db=%0d zero=%b, required edges=%0d db=%0d zero=%b",
                         n, x, edges, snr_db, zero_input, (x == 0) ? 1 : 11, exp_db, x == 0);
            end
            release_start();
        end
    endtask

    initial begin
        test_reset();
        test_known();
        test_busy();
        test_handshake();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
